// File: rtl/blackjack_pkg.sv
// Purpose: shared types and constants for the blackjack round logic.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
//
// Contents:
//   card_t   - 5-bit card value, 1..11 (ace counted as 11 by the card source)
//   hand_t   - 6-bit hand sum, unsigned, max 55
//   result_t - round outcome encoding, NONE=00 PLAYER=01 DEALER=10 PUSH=11
//   state_t  - round sequencer FSM states
//   settleHands() - outcome from the two final sums (bust rules, then compare)
package blackjack_pkg;

    typedef logic [4:0] card_t;
    typedef logic [5:0] hand_t;

    typedef enum logic [1:0] {
        RES_NONE   = 2'b00,
        RES_PLAYER = 2'b01,
        RES_DEALER = 2'b10,
        RES_PUSH   = 2'b11
    } result_t;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_CLEAR       = 4'd1,
        ST_DEAL        = 4'd2,
        ST_PLAYER_TURN = 4'd3,
        ST_PLAYER_DRAW = 4'd4,
        ST_DEALER_TURN = 4'd5,
        ST_DEALER_DRAW = 4'd6,
        ST_SETTLE      = 4'd7,
        ST_DONE        = 4'd8
    } state_t;

    localparam int BJ_LIMIT             = 21;
    localparam int DEFAULT_DEALER_STAND = 17;

    // Player bust is checked first so a busted player loses even if the
    // dealer's sum is also over the limit.
    function automatic result_t settleHands(input hand_t playerSum, input hand_t dealerSum);
        result_t res;
        if (playerSum > hand_t'(BJ_LIMIT))
            res = RES_DEALER;
        else if (dealerSum > hand_t'(BJ_LIMIT))
            res = RES_PLAYER;
        else if (playerSum > dealerSum)
            res = RES_PLAYER;
        else if (playerSum < dealerSum)
            res = RES_DEALER;
        else
            res = RES_PUSH;
        return res;
    endfunction

endpackage

// File: rtl/card_fetch.sv
// Purpose: one card draw - request a card, latch it, strobe it into the selected hand, let sums settle.
// Latency: 3 cycles from the first request cycle with a card ready (FETCH, ADD, WAIT); o_done high in WAIT.
// Backpressure: o_card_req is held in FETCH until i_card_valid; nothing downstream can stall.
//
// Ports:
//   i_clk, i_reset_n          - clock, synchronous active-low reset
//   i_start, i_toDealer       - begin a draw next cycle; target hand (0 player, 1 dealer)
//   o_done                    - high for the WAIT cycle; hand sums are valid then
//   o_card_req, i_card_valid  - card source handshake, transfer when both high
//   i_card, o_new_card        - incoming card and its latched copy for the hands
//   o_player_add, o_dealer_add- one-cycle add strobes, never together
module card_fetch
    import blackjack_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_reset_n,
    input  logic  i_start,
    input  logic  i_toDealer,
    output logic  o_done,
    output logic  o_card_req,
    input  logic  i_card_valid,
    input  card_t i_card,
    output card_t o_new_card,
    output logic  o_player_add,
    output logic  o_dealer_add
);

    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_FETCH = 2'd1;
    localparam logic [1:0] PH_ADD   = 2'd2;
    localparam logic [1:0] PH_WAIT  = 2'd3;

    logic [1:0] phase;
    logic       toDealer;

    // The request flop is set on the start edge so it is already high in the
    // first FETCH cycle, and cleared on the transfer edge.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            phase        <= PH_IDLE;
            toDealer     <= 1'b0;
            o_card_req   <= 1'b0;
            o_new_card   <= '0;
            o_player_add <= 1'b0;
            o_dealer_add <= 1'b0;
        end else begin
            o_player_add <= 1'b0;
            o_dealer_add <= 1'b0;
            case (phase)
                PH_IDLE, PH_WAIT: begin
                    // A start seen during WAIT chains the next draw with no gap.
                    if (i_start) begin
                        phase      <= PH_FETCH;
                        toDealer   <= i_toDealer;
                        o_card_req <= 1'b1;
                    end else begin
                        phase <= PH_IDLE;
                    end
                end
                PH_FETCH: begin
                    if (i_card_valid) begin
                        phase        <= PH_ADD;
                        o_new_card   <= i_card;
                        o_card_req   <= 1'b0;
                        o_player_add <= ~toDealer;
                        o_dealer_add <= toDealer;
                    end
                end
                default: begin
                    phase <= PH_WAIT;
                end
            endcase
        end
    end

    assign o_done = (phase == PH_WAIT);

endmodule

// File: rtl/round_sequencer.sv
// Purpose: sequences one blackjack round: deal four cards, player turn, dealer play, settle.
// Latency: deal to first card request 2 cycles; each draw 3 cycles with the card source always ready.
// Backpressure: waits indefinitely on i_card_valid; i_deal ignored while busy, hit/stand only in player turn.
//
// Ports:
//   i_clk, i_reset_n                 - clock, synchronous active-low reset
//   i_deal, i_hit, i_stand           - user request pulses
//   o_card_req, i_card_valid, i_card - card source handshake
//   o_new_card, o_player_add, o_dealer_add, o_hands_reset - to the two hand accumulators
//   i_player_sum/count, i_dealer_sum/count - from the two hand accumulators
//   o_dealer_hidden, o_result, o_result_valid, o_busy     - to display logic
//
// Build option: FIVE_CARD_CHARLIE_EN - a player holding MAX_CARDS cards without
// busting wins outright and the dealer does not play. Undefined, a full hand
// simply ends the player's turn.
module round_sequencer
    import blackjack_pkg::*;
#(
    parameter int DEALER_STAND = DEFAULT_DEALER_STAND,
    parameter int MAX_CARDS    = 5
) (
    input  logic    i_clk,
    input  logic    i_reset_n,
    input  logic    i_deal,
    input  logic    i_hit,
    input  logic    i_stand,
    output logic    o_card_req,
    input  logic    i_card_valid,
    input  card_t   i_card,
    output card_t   o_new_card,
    output logic    o_player_add,
    output logic    o_dealer_add,
    output logic    o_hands_reset,
    input  hand_t   i_player_sum,
    input  hand_t   i_dealer_sum,
    input  logic [2:0] i_player_count,
    input  logic [2:0] i_dealer_count,
    output logic    o_dealer_hidden,
    output result_t o_result,
    output logic    o_result_valid,
    output logic    o_busy
);

    state_t     state;
    logic [1:0] dealIdx;

    logic fetchStart;
    logic fetchToDealer;
    logic fetchDone;

    logic    playerHas21;
    logic    playerBust;
    logic    playerFull;
    logic    dealerMustDraw;
    result_t settleResult;

    assign playerHas21    = (i_player_sum == hand_t'(BJ_LIMIT));
    assign playerBust     = (i_player_sum >  hand_t'(BJ_LIMIT));
    assign playerFull     = (i_player_count == 3'(MAX_CARDS));
    assign dealerMustDraw = (i_dealer_sum < hand_t'(DEALER_STAND)) &&
                            (i_dealer_count < 3'(MAX_CARDS));

    always_comb begin
        settleResult = settleHands(i_player_sum, i_dealer_sum);
`ifdef FIVE_CARD_CHARLIE_EN
        // Only reachable with a full hand via the charlie exit from PLAYER_DRAW.
        if (!playerBust && playerFull)
            settleResult = RES_PLAYER;
`endif
    end

    // Draw starts are issued on the same cycle the FSM decides to move into
    // a draw state, so the fetcher's registered request lines up with it.
    always_comb begin
        fetchStart    = 1'b0;
        fetchToDealer = 1'b0;
        case (state)
            ST_CLEAR: begin
                fetchStart = 1'b1;
            end
            ST_DEAL: begin
                // Deal order P,D,P,D: the next card goes to the dealer when
                // the card just finished was an even (player) index.
                if (fetchDone && (dealIdx != 2'd3)) begin
                    fetchStart    = 1'b1;
                    fetchToDealer = ~dealIdx[0];
                end
            end
            ST_PLAYER_TURN: begin
                if (i_hit && !i_stand && !playerHas21)
                    fetchStart = 1'b1;
            end
            ST_DEALER_TURN: begin
                if (dealerMustDraw) begin
                    fetchStart    = 1'b1;
                    fetchToDealer = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state           <= ST_IDLE;
            dealIdx         <= 2'd0;
            o_hands_reset   <= 1'b0;
            o_dealer_hidden <= 1'b0;
            o_result        <= RES_NONE;
            o_result_valid  <= 1'b0;
        end else begin
            o_hands_reset <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_deal) begin
                        state           <= ST_CLEAR;
                        o_hands_reset   <= 1'b1;
                        o_dealer_hidden <= 1'b1;
                        o_result        <= RES_NONE;
                        o_result_valid  <= 1'b0;
                        dealIdx         <= 2'd0;
                    end
                end
                ST_CLEAR: begin
                    state <= ST_DEAL;
                end
                ST_DEAL: begin
                    if (fetchDone) begin
                        if (dealIdx == 2'd3)
                            state <= ST_PLAYER_TURN;
                        else
                            dealIdx <= dealIdx + 2'd1;
                    end
                end
                ST_PLAYER_TURN: begin
                    // A natural 21 behaves as an immediate stand; stand beats hit.
                    if (i_stand || playerHas21)
                        state <= ST_DEALER_TURN;
                    else if (i_hit)
                        state <= ST_PLAYER_DRAW;
                end
                ST_PLAYER_DRAW: begin
                    if (fetchDone) begin
                        if (playerBust) begin
                            state <= ST_SETTLE;
`ifdef FIVE_CARD_CHARLIE_EN
                        end else if (playerFull) begin
                            state           <= ST_SETTLE;
                            o_dealer_hidden <= 1'b0;
`endif
                        end else if (playerHas21 || playerFull) begin
                            state <= ST_DEALER_TURN;
                        end else begin
                            state <= ST_PLAYER_TURN;
                        end
                    end
                end
                ST_DEALER_TURN: begin
                    o_dealer_hidden <= 1'b0;
                    if (dealerMustDraw)
                        state <= ST_DEALER_DRAW;
                    else
                        state <= ST_SETTLE;
                end
                ST_DEALER_DRAW: begin
                    if (fetchDone)
                        state <= ST_DEALER_TURN;
                end
                ST_SETTLE: begin
                    o_result       <= settleResult;
                    o_result_valid <= 1'b1;
                    state          <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy = (state != ST_IDLE) && (state != ST_DONE);

    card_fetch u_cardFetch (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_start      (fetchStart),
        .i_toDealer   (fetchToDealer),
        .o_done       (fetchDone),
        .o_card_req   (o_card_req),
        .i_card_valid (i_card_valid),
        .i_card       (i_card),
        .o_new_card   (o_new_card),
        .o_player_add (o_player_add),
        .o_dealer_add (o_dealer_add)
    );

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: emulates the card source and both hand
// accumulators, drives directed and random rounds, and compares outcomes with
// a round-level model of the game rules.
module tb_round_sequencer;
    import blackjack_pkg::*;

    localparam int MAXC   = 5;
    localparam int DSTAND = 17;

    logic       i_clk = 1'b0;
    logic       i_reset_n;
    logic       i_deal, i_hit, i_stand;
    logic       o_card_req;
    logic       i_card_valid;
    card_t      i_card;
    card_t      o_new_card;
    logic       o_player_add, o_dealer_add, o_hands_reset;
    hand_t      pSum = '0, dSum = '0;
    logic [2:0] pCnt = '0, dCnt = '0;
    logic       o_dealer_hidden;
    result_t    o_result;
    logic       o_result_valid, o_busy;

    always #5 i_clk = ~i_clk;

    round_sequencer #(.DEALER_STAND(DSTAND), .MAX_CARDS(MAXC)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_deal(i_deal), .i_hit(i_hit), .i_stand(i_stand),
        .o_card_req(o_card_req), .i_card_valid(i_card_valid), .i_card(i_card),
        .o_new_card(o_new_card), .o_player_add(o_player_add), .o_dealer_add(o_dealer_add),
        .o_hands_reset(o_hands_reset),
        .i_player_sum(pSum), .i_dealer_sum(dSum),
        .i_player_count(pCnt), .i_dealer_count(dCnt),
        .o_dealer_hidden(o_dealer_hidden), .o_result(o_result),
        .o_result_valid(o_result_valid), .o_busy(o_busy)
    );

    int checks = 0;
    int errors = 0;

    // Card source state: the main sequence loads cardArr/nCards/base, the
    // monitor only advances consumed.
    int  cardArr[16];
    int  nCards   = 0;
    int  base     = 0;
    int  stallPct = 0;
    bit  holdLow  = 1'b0;
    int  consumed = 0;
    int  pAdds = 0, dAdds = 0, bothAdds = 0;

    // Hand accumulators and transfer/strobe counters.
    always @(posedge i_clk) begin
        if (i_reset_n && o_card_req && i_card_valid)
            consumed <= consumed + 1;
        if (o_player_add) pAdds <= pAdds + 1;
        if (o_dealer_add) dAdds <= dAdds + 1;
        if (o_player_add && o_dealer_add) bothAdds <= bothAdds + 1;
        if (o_hands_reset) begin
            pSum <= '0; dSum <= '0; pCnt <= '0; dCnt <= '0;
        end else begin
            if (o_player_add) begin pSum <= pSum + hand_t'(o_new_card); pCnt <= pCnt + 3'd1; end
            if (o_dealer_add) begin dSum <= dSum + hand_t'(o_new_card); dCnt <= dCnt + 3'd1; end
        end
    end

    // Card source driver, updated just after the falling edge.
    initial begin
        int idx;
        i_card_valid = 1'b0;
        i_card       = '0;
        forever begin
            @(negedge i_clk);
            #1;
            idx = consumed - base;
            if (idx < nCards && !holdLow && int'($urandom_range(0, 99)) >= stallPct) begin
                i_card_valid = 1'b1;
                i_card       = card_t'(cardArr[idx]);
            end else begin
                i_card_valid = 1'b0;
                i_card       = '0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Round-level rules model: the player hits while below thr (never at 21
    // or with a full hand), the dealer draws below DSTAND with room left.
    function automatic void model(input int c[16], input int thr,
                                  output logic [1:0] res, output int nP, output int nD,
                                  output bit hid, output bit needStand);
        int ps, ds, k;
        ps = c[0] + c[2]; ds = c[1] + c[3];
        nP = 2; nD = 2; k = 4; hid = 1'b0;
        while (ps < 21 && ps < thr && nP < MAXC) begin ps += c[k]; k++; nP++; end
        needStand = (ps < 21) && (nP < MAXC);
        if (ps > 21) begin res = 2'b10; hid = 1'b1; return; end
`ifdef FIVE_CARD_CHARLIE_EN
        if (nP == MAXC) begin res = 2'b01; return; end
`endif
        while (ds < DSTAND && nD < MAXC) begin ds += c[k]; k++; nD++; end
        if (ds > 21)       res = 2'b01;
        else if (ps > ds)  res = 2'b01;
        else if (ps < ds)  res = 2'b10;
        else               res = 2'b11;
    endfunction

    task automatic waitAdds(input int target, input string tag);
        int k = 0;
        while ((pAdds + dAdds) < target && k < 3000) begin @(negedge i_clk); k++; end
        check(tag, pAdds + dAdds, target);
    endtask

    task automatic waitResult(input string tag);
        int k = 0;
        while (o_result_valid !== 1'b1 && k < 3000) begin @(negedge i_clk); k++; end
        check(tag, o_result_valid, 1);
    endtask

    task automatic pulseDeal();
        @(negedge i_clk); i_deal = 1'b1;
        @(negedge i_clk); i_deal = 1'b0;
    endtask

    task automatic runRound(input string nm, input int c[16], input int thr, input int pct,
                            input bit hitInDeal, input bit bothPress, input bit holdTest);
        logic [1:0] expRes;
        int nP, nD, hits, c0, a0, p0, d0, b0;
        bit hid, needStand;
        model(c, thr, expRes, nP, nD, hid, needStand);
        hits = nP - 2;
        @(negedge i_clk);
        base = consumed; cardArr = c; nCards = 16; stallPct = pct;
        c0 = consumed; p0 = pAdds; d0 = dAdds; b0 = bothAdds; a0 = pAdds + dAdds;
        i_deal = 1'b1; i_hit = hitInDeal;
        @(negedge i_clk); i_deal = 1'b0;
        check({nm, " hands_reset"}, o_hands_reset, 1);
        check({nm, " busy"}, o_busy, 1);
        @(negedge i_clk);
        check({nm, " first req"}, o_card_req, 1);
        @(negedge i_clk); i_hit = 1'b0;
        for (int i = 0; i < hits; i++) begin
            waitAdds(a0 + 4 + i, {nm, " adds before hit"});
            repeat (2) @(negedge i_clk);
            if (holdTest && i == 0) holdLow = 1'b1;
            i_hit = 1'b1;
            @(negedge i_clk); i_hit = 1'b0;
            if (holdTest && i == 0) begin
                for (int j = 0; j < 10; j++) begin
                    check({nm, " held req"}, o_card_req, 1);
                    check({nm, " no strobe"}, {o_player_add, o_dealer_add}, 0);
                    @(negedge i_clk);
                end
                check({nm, " no add while invalid"}, pAdds + dAdds, a0 + 4);
                holdLow = 1'b0;
            end
        end
        if (needStand) begin
            waitAdds(a0 + 2 + nP, {nm, " adds before stand"});
            repeat (2) @(negedge i_clk);
            i_stand = 1'b1; i_hit = bothPress;
            @(negedge i_clk); i_stand = 1'b0; i_hit = 1'b0;
        end
        waitResult({nm, " result_valid"});
        check({nm, " result"}, o_result, expRes);
        check({nm, " transfers"}, consumed - c0, nP + nD);
        check({nm, " player adds"}, pAdds - p0, nP);
        check({nm, " dealer adds"}, dAdds - d0, nD);
        check({nm, " strobe overlap"}, bothAdds - b0, 0);
        check({nm, " dealer_hidden"}, o_dealer_hidden, hid);
        check({nm, " busy done"}, o_busy, 0);
        stallPct = 0; base = consumed; nCards = 0;
    endtask

    initial begin
        int c[16];
        int thr, k, c0, d0;
        i_reset_n = 1'b0; i_deal = 1'b0; i_hit = 1'b0; i_stand = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst card_req", o_card_req, 0);
        check("rst busy", o_busy, 0);
        check("rst result_valid", o_result_valid, 0);
        check("rst result", o_result, 0);
        check("rst hidden", o_dealer_hidden, 0);
        check("rst new_card", o_new_card, 0);
        check("rst strobes", {o_player_add, o_dealer_add, o_hands_reset}, 0);
        i_reset_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // Reset while the dealer's draw is waiting on the card source.
        c = '{10, 10, 8, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        base = consumed; cardArr = c; nCards = 4; c0 = consumed;
        pulseDeal();
        waitAdds(pAdds + dAdds + 4 - ((consumed - c0) > 4 ? 0 : (consumed - c0)), "rst-draw deal adds");
        repeat (2) @(negedge i_clk);
        i_stand = 1'b1;
        @(negedge i_clk); i_stand = 1'b0;
        k = 0;
        while (o_card_req !== 1'b1 && k < 100) begin @(negedge i_clk); k++; end
        repeat (3) @(negedge i_clk);
        check("rst-draw req held", o_card_req, 1);
        check("rst-draw hidden cleared", o_dealer_hidden, 0);
        d0 = dAdds;
        cardArr[4] = 5; nCards = 5; i_reset_n = 1'b0;
        @(negedge i_clk);
        i_reset_n = 1'b1; nCards = 0; base = consumed;
        check("rst-draw card_req", o_card_req, 0);
        check("rst-draw busy", o_busy, 0);
        check("rst-draw new_card", o_new_card, 0);
        check("rst-draw hidden", o_dealer_hidden, 0);
        check("rst-draw result", {o_result_valid, o_result}, 0);
        check("rst-draw strobes", {o_player_add, o_dealer_add, o_hands_reset}, 0);
        repeat (3) @(negedge i_clk);
        check("rst-draw no late add", dAdds - d0, 0);
        check("rst-draw idle req", o_card_req, 0);

        // Push, with hit held during the deal.
        c = '{10, 9, 8, 7, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        runRound("push", c, 17, 0, 1'b1, 1'b0, 1'b0);
        // Player bust after a long card-source stall.
        c = '{10, 10, 6, 7, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        runRound("pbust", c, 17, 0, 1'b0, 1'b0, 1'b1);
        // Dealer bust, hit and stand pressed together.
        c = '{10, 10, 9, 6, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        runRound("dbust", c, 17, 0, 1'b0, 1'b1, 1'b0);
        // Five cards without busting.
        c = '{2, 10, 2, 7, 2, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        runRound("five", c, 21, 20, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 16; i++) c[i] = int'($urandom_range(1, 11));
            thr = int'($urandom_range(12, 21));
            runRound("rand", c, thr, int'($urandom_range(0, 60)), $urandom_range(0, 1) == 1,
                     $urandom_range(0, 1) == 1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Sequences one blackjack round across the shared card source and the two hand-accumulator instances (player, dealer). Deals the opening four cards, services player hit/stand requests, plays the dealer to its stand threshold, and settles the result. Sits between the deck/card source, the two hand accumulators, and the user-input/display logic.

## Interface
- DEALER_STAND, default 17: dealer stops drawing at sum ≥ this value.
- MAX_CARDS, default 5: card capacity per hand; the player is forced to stop at this count.
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_deal  in  1  start-round pulse; honoured only in IDLE or DONE.
- i_hit  in  1  player hit pulse; honoured only in PLAYER_TURN.
- i_stand  in  1  player stand pulse; honoured only in PLAYER_TURN.
- o_card_req  out  1  card request to the card source; held until accepted.
- i_card_valid  in  1  card source has a card; a transfer occurs on a cycle with o_card_req & i_card_valid.
- i_card  in  card_t  card value, 1..11 (ace = 11).
- o_new_card  out  card_t  captured card, driven to both hands.
- o_player_add / o_dealer_add  out  1  one-cycle add strobe to the selected hand.
- o_hands_reset  out  1  one-cycle clear strobe to both hands.
- i_player_sum / i_dealer_sum  in  hand_t  hand sums.
- i_player_count / i_dealer_count  in  3  cards held per hand.
- o_dealer_hidden  out  1  high while the dealer's second card must not be displayed.
- o_result  out  result_t  NONE=00, PLAYER=01, DEALER=10, PUSH=11.
- o_result_valid  out  1  high in DONE.
- o_busy  out  1  high in every state except IDLE and DONE.

## Operation
- States: IDLE, CLEAR, DEAL (4 sub-steps P,D,P,D via 2-bit deal index), PLAYER_TURN, PLAYER_DRAW, DEALER_TURN, DEALER_DRAW, SETTLE, DONE.
- Draw sub-sequence, shared by DEAL, PLAYER_DRAW and DEALER_DRAW, with phases FETCH→ADD→WAIT:
  - FETCH: assert o_card_req until transfer, then latch i_card into o_new_card.
  - ADD: pulse the selected add strobe for exactly one cycle.
  - WAIT: one idle cycle so the hand sums settle before evaluation.
- IDLE/DONE + i_deal → CLEAR: pulse o_hands_reset, zero o_result, clear o_result_valid, raise o_dealer_hidden, reset the deal index → DEAL.
- After the 4th deal card → PLAYER_TURN. If the player sum is 21, transition automatically as if stand was pressed.
- PLAYER_TURN:
  - i_hit → PLAYER_DRAW.
  - i_stand → DEALER_TURN.
  - i_hit and i_stand in the same cycle: stand wins.
- After PLAYER_DRAW:
  - sum > 21 → SETTLE (player bust); the dealer draws nothing.
  - sum = 21 or count = MAX_CARDS → DEALER_TURN.
  - otherwise → PLAYER_TURN.
- DEALER_TURN: clear o_dealer_hidden. Dealer sum < DEALER_STAND and count < MAX_CARDS → DEALER_DRAW, which returns to DEALER_TURN; otherwise → SETTLE.
- SETTLE, evaluated in order:
  1. player bust → DEALER.
  2. dealer bust → PLAYER.
  3. player > dealer → PLAYER.
  4. player < dealer → DEALER.
  5. equal → PUSH.
  Then → DONE.
- Sum comparison is unsigned on hand_t (6 bits, max 55). Sums are never modified here.
- i_deal while o_busy is ignored. i_hit/i_stand outside PLAYER_TURN are ignored and never queued.

## Timing
- Reset (i_reset_n=0 at a clock edge), from any state including mid-draw:
  - state → IDLE.
  - o_card_req, o_player_add, o_dealer_add, o_hands_reset, o_result_valid, o_busy = 0.
  - o_dealer_hidden = 0; o_result = NONE; o_new_card = 0.
  - A card offered during reset is not accepted.
- Hand clearing: the external hands are cleared only by o_hands_reset, never by reset alone.
- Deal to first o_card_req: 2 cycles (CLEAR, then DEAL/FETCH).
- Draw cost: (cycles waiting for i_card_valid) + 1 transfer + ADD + WAIT. With i_card_valid held high, a draw takes 3 cycles.
- o_card_req is registered and drops the cycle after the transfer.
- o_player_add and o_dealer_add are never high together.
- o_result is stable whenever o_result_valid=1. Both are set in the same edge, on entry to DONE.

## Configuration
- FIVE_CARD_CHARLIE_EN defined:
  - A player reaching MAX_CARDS with sum ≤ 21 → SETTLE with o_result=PLAYER.
  - The dealer does not draw, and o_dealer_hidden clears.
- Undefined: MAX_CARDS behaves as stand.

## Structure
- blackjack_pkg holds:
  - card_t (5-bit), hand_t (6-bit), result_t enum, state_t enum.
  - BJ_LIMIT=21, DEFAULT_DEALER_STAND=17.
- Sub-module card_fetch owns the FETCH/ADD/WAIT handshake. Interface: start, target-select, done, o_card_req, o_new_card, add strobes. The top-level FSM only starts it and waits for done.

## Test plan
- Reset mid-DEALER_DRAW with o_card_req high → next cycle all outputs at reset values, state IDLE; a later i_deal starts cleanly with o_hands_reset pulsing.
- Deal 10,8 / 9,7 (player/dealer), stand; dealer draws 2 → dealer 18 vs player 18 → PUSH. Check exactly 5 transfers and 5 add strobes, correctly routed.
- Deal 10,6 / 10,7, hit draws 9 → player 25 → DEALER. Check no dealer draw and o_dealer_hidden stays high.
- Deal 10,9 / 10,6, stand, dealer draws 10 → dealer 26 → PLAYER.
- Deal 2,2 / 10,7, hit 2,3,3 (player 12, 5 cards):
  - with FIVE_CARD_CHARLIE_EN → PLAYER, no dealer draw.
  - without → dealer stands at 17 → DEALER.
- Hold i_card_valid low 10 cycles during a draw → o_card_req held and no strobe until valid. Also check: i_hit during DEAL ignored; simultaneous hit+stand → stand.
